// File: rtl/led_display_row_scheduler.sv
// LED matrix scan sequencer: fetches a row pair, streams it to the PHY, waits
// for the latch, then shows it on the panel's row address/OE for a fixed time.
package led_display_row_scheduler_pkg;
    localparam int GL_NUM_COL_PIXELS = 64;
    typedef logic [3*GL_NUM_COL_PIXELS-1:0] pxl_col_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_WAIT_DATA, ST_WAIT_READY, ST_SHIFT, ST_BLANK, ST_DISPLAY
    } state_t;
endpackage

module led_display_row_scheduler
    import led_display_row_scheduler_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PAIRS  = 16,
    parameter int ROW_ADDR_W     = 4,
    parameter int DISPLAY_CYCLES = 2048,
    parameter int BLANK_CYCLES   = 4,
    parameter int LATCH_TIMEOUT  = 256
) (
    input  logic                  clk_in,
    input  logic                  n_reset_in,
    input  logic                  enable_in,
    output logic                  fb_rd_en_out,
    output logic [ROW_ADDR_W-1:0] fb_rd_addr_out,
    input  logic                  fb_rd_valid_in,
    input  pxl_col_t              fb_row_top_in,
    input  pxl_col_t              fb_row_bot_in,
    output logic                  phy_row_valid_out,
    output pxl_col_t              phy_row_top_out,
    output pxl_col_t              phy_row_bot_out,
    input  logic                  phy_row_ready_in,
    input  logic                  phy_latch_in,
    output logic [ROW_ADDR_W-1:0] row_addr_out,
    output logic                  oe_n_out,
    output logic                  frame_start_out,
    output logic                  busy_out,
    output logic                  error_out,
    output state_t                state_out
);

    localparam int CNT_MAX =
        (DISPLAY_CYCLES > LATCH_TIMEOUT)
            ? ((DISPLAY_CYCLES > BLANK_CYCLES) ? DISPLAY_CYCLES : BLANK_CYCLES)
            : ((LATCH_TIMEOUT  > BLANK_CYCLES) ? LATCH_TIMEOUT  : BLANK_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    if (SYS_CLK_FREQ < 1 || DISPLAY_CYCLES < 1 || BLANK_CYCLES < 1 || LATCH_TIMEOUT < 1 ||
        (1 << ROW_ADDR_W) < NUM_ROW_PAIRS) begin : g_param_check
        $error("led_display_row_scheduler: illegal parameter set");
    end

    state_t                state_q, state_d;
    logic [ROW_ADDR_W-1:0] next_row_q, next_row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROW_ADDR_W-1:0] row_addr_d, fb_rd_addr_d;
    logic                  fb_rd_en_d, valid_d, oe_n_d, frame_start_d, busy_d, error_d;
    pxl_col_t              top_d, bot_d;

    assign state_out = state_q;

    // State and every output are registered here; *_d values come from the comb blocks.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q           <= ST_IDLE;
            next_row_q        <= '0;
            cnt_q             <= '0;
            row_addr_out      <= '0;
            oe_n_out          <= 1'b1;
            fb_rd_en_out      <= 1'b0;
            fb_rd_addr_out    <= '0;
            phy_row_valid_out <= 1'b0;
            phy_row_top_out   <= '0;
            phy_row_bot_out   <= '0;
            frame_start_out   <= 1'b0;
            busy_out          <= 1'b0;
            error_out         <= 1'b0;
        end else begin
            state_q           <= state_d;
            next_row_q        <= next_row_d;
            cnt_q             <= cnt_d;
            row_addr_out      <= row_addr_d;
            oe_n_out          <= oe_n_d;
            fb_rd_en_out      <= fb_rd_en_d;
            fb_rd_addr_out    <= fb_rd_addr_d;
            phy_row_valid_out <= valid_d;
            phy_row_top_out   <= top_d;
            phy_row_bot_out   <= bot_d;
            frame_start_out   <= frame_start_d;
            busy_out          <= busy_d;
            error_out         <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (enable_in) state_d = ST_FETCH;
            ST_FETCH:      state_d = ST_WAIT_DATA;
            ST_WAIT_DATA:  if (fb_rd_valid_in) state_d = ST_WAIT_READY;
            ST_WAIT_READY: if (phy_row_ready_in) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (phy_latch_in)                               state_d = ST_BLANK;
                else if (cnt_q == CNT_W'(LATCH_TIMEOUT - 1))    state_d = ST_IDLE;
            end
            ST_BLANK:      if (cnt_q == CNT_W'(1)) state_d = ST_DISPLAY;
            ST_DISPLAY: begin
                if (cnt_q == CNT_W'(1)) state_d = enable_in ? ST_FETCH : ST_IDLE;
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    // Row stream to the PHY: valid is raised only for the cycle after ready was seen
    // in WAIT_READY, and the row data stays put from capture until the next fetch.
    always_comb begin
        cnt_d      = cnt_q;
        next_row_d = next_row_q;
        row_addr_d = row_addr_out;
        top_d      = phy_row_top_out;
        bot_d      = phy_row_bot_out;
        error_d    = error_out;
        valid_d    = 1'b0;
        case (state_q)
            ST_WAIT_DATA: begin
                if (fb_rd_valid_in) begin
                    top_d = fb_row_top_in;
                    bot_d = fb_row_bot_in;
                end
            end
            ST_WAIT_READY: begin
                if (phy_row_ready_in) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (phy_latch_in) begin
                    row_addr_d = next_row_q;
                    cnt_d      = CNT_W'(BLANK_CYCLES);
                end else if (cnt_q == CNT_W'(LATCH_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                end
            end
            ST_BLANK: begin
                cnt_d = (cnt_q == CNT_W'(1)) ? CNT_W'(DISPLAY_CYCLES) : cnt_q - 1'b1;
            end
            ST_DISPLAY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    next_row_d = (next_row_q == ROW_ADDR_W'(NUM_ROW_PAIRS - 1)) ? '0
                                                                             : next_row_q + 1'b1;
                end
            end
            default: ;
        endcase
        fb_rd_en_d    = (state_d == ST_FETCH);
        fb_rd_addr_d  = (state_d == ST_FETCH) ? next_row_d : fb_rd_addr_out;
        frame_start_d = (state_d == ST_FETCH) && (next_row_d == '0);
        oe_n_d        = (state_d != ST_DISPLAY);
        busy_d        = (state_d != ST_IDLE);
    end

endmodule
